// File: rtl/mii_rx_framer_if.sv
// MII receive nibble inputs and payload byte stream outputs of mii_rx_framer.
// The master view belongs to the framer and the slave view to the PHY/sink side.
interface mii_rx_framer_if;
    logic [3:0] mii_rx_data;
    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic [3:0] m_tuser;

    modport master (
        input  mii_rx_data, mii_rx_dv, mii_rx_er,
        output m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport slave (
        output mii_rx_data, mii_rx_dv, mii_rx_er,
        input  m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/mii_rx_framer.sv
// MII receive framer: preamble/SFD detection, nibble-to-byte assembly, CRC-32 check, FCS strip.
// Optional frame counters are enabled by defining MII_RX_FRAMER_STATS_EN.
module mii_rx_framer #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic            clk,
    input  logic            reset,
    mii_rx_framer_if.master bus
`ifdef MII_RX_FRAMER_STATS_EN
    ,
    output logic [31:0]     stat_frames_ok,
    output logic [31:0]     stat_frames_err,
    output logic [31:0]     stat_runts
`endif
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam int          DEPTH       = 5;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] OVER_LEN    = 11'(MAX_FRAME_LEN + 1);
    localparam logic [10:0] CNT_MAX     = 11'd2047;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [3:0]  NIB_PRE     = 4'h5;
    localparam logic [3:0]  NIB_SFD     = 4'hD;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
            else      c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] crc_r;
    logic [10:0] byte_cnt_r;
    logic [3:0]  nib_lo_r;
    logic        phase_r;
    logic        er_seen_r;
    logic [7:0]  dl_r [DEPTH];

    logic [7:0]  tdata_r;
    logic        tvalid_r, tlast_r;
    logic [3:0]  tuser_r;

    logic        dv_s, er_now_s, byte_done_s, full_s, overlong_s;
    logic [3:0]  nib_s;
    logic [7:0]  byte_s;
    logic [10:0] cnt_next_s;
    logic        emit_s, last_s, runt_s;
    logic [3:0]  user_s;

    assign dv_s        = bus.mii_rx_dv;
    assign nib_s       = bus.mii_rx_data;
    assign er_now_s    = bus.mii_rx_dv & bus.mii_rx_er;
    assign byte_s      = {nib_s, nib_lo_r};
    assign byte_done_s = (state_r == DATA) && dv_s && phase_r;
    assign full_s      = (byte_cnt_r >= 11'd5);
    assign cnt_next_s  = (byte_cnt_r == CNT_MAX) ? byte_cnt_r : byte_cnt_r + 11'd1;
    assign overlong_s  = byte_done_s && (cnt_next_s == OVER_LEN);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!dv_s)                 state_s = IDLE;
                else if (nib_s == NIB_PRE) state_s = PREAMBLE;
                else                       state_s = DROP;
            end
            PREAMBLE: begin
                if (!dv_s)                 state_s = IDLE;
                else if (nib_s == NIB_PRE) state_s = PREAMBLE;
                else if (nib_s == NIB_SFD) state_s = DATA;
                else                       state_s = DROP;
            end
            DATA: begin
                if (!dv_s)           state_s = IDLE;
                else if (overlong_s) state_s = DROP;
                else                 state_s = DATA;
            end
            DROP: begin
                if (!dv_s) state_s = IDLE;
                else       state_s = DROP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Beat, status and drop decisions; the beat always carries the oldest held byte
    always_comb begin
        emit_s = 1'b0;
        last_s = 1'b0;
        user_s = 4'd0;
        runt_s = 1'b0;
        case (state_r)
            IDLE: begin
                runt_s = dv_s && (nib_s != NIB_PRE);
            end
            PREAMBLE: begin
                runt_s = !dv_s || ((nib_s != NIB_PRE) && (nib_s != NIB_SFD));
            end
            DATA: begin
                if (!dv_s) begin
                    if (full_s) begin
                        emit_s = 1'b1;
                        last_s = 1'b1;
                        user_s = {byte_cnt_r < MIN_LEN, phase_r, er_seen_r, crc_r != CRC_RESIDUE};
                    end else begin
                        runt_s = 1'b1;
                    end
                end else if (byte_done_s && full_s) begin
                    emit_s = 1'b1;
                    if (overlong_s) begin
                        last_s = 1'b1;
                        user_s = {1'b1, 1'b0, er_seen_r | er_now_s, 1'b0};
                    end else begin
                        last_s = 1'b0;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: begin
                emit_s = 1'b0;
            end
        endcase
    end

    // Byte assembly, CRC, length count, delay line and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_r      <= CRC_INIT;
            byte_cnt_r <= 11'd0;
            nib_lo_r   <= 4'd0;
            phase_r    <= 1'b0;
            er_seen_r  <= 1'b0;
            tdata_r    <= 8'd0;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            tuser_r    <= 4'd0;
            for (int i = 0; i < DEPTH; i++) dl_r[i] <= 8'd0;
        end else begin
            tvalid_r <= emit_s;
            tlast_r  <= last_s;
            tuser_r  <= user_s;
            tdata_r  <= emit_s ? dl_r[DEPTH-1] : 8'd0;
            // rx_er history restarts with the first dv cycle seen from IDLE
            if (state_r == IDLE) er_seen_r <= er_now_s;
            else                 er_seen_r <= er_seen_r | er_now_s;
            case (state_r)
                PREAMBLE: begin
                    if (dv_s && (nib_s == NIB_SFD)) begin
                        phase_r    <= 1'b0;
                        crc_r      <= CRC_INIT;
                        byte_cnt_r <= 11'd0;
                    end
                end
                DATA: begin
                    if (dv_s && !phase_r) begin
                        nib_lo_r <= nib_s;
                        phase_r  <= 1'b1;
                    end else if (dv_s) begin
                        phase_r    <= 1'b0;
                        crc_r      <= crc32_byte(crc_r, byte_s);
                        byte_cnt_r <= cnt_next_s;
                        for (int i = DEPTH - 1; i > 0; i--) dl_r[i] <= dl_r[i-1];
                        dl_r[0] <= byte_s;
                    end
                end
                default: begin
                    phase_r <= phase_r;
                end
            endcase
        end
    end

    assign bus.m_tdata  = tdata_r;
    assign bus.m_tvalid = tvalid_r;
    assign bus.m_tlast  = tlast_r;
    assign bus.m_tuser  = tuser_r;

`ifdef MII_RX_FRAMER_STATS_EN
    logic        runt_r;
    logic [31:0] ok_r, err_r, runts_r;

    // Frame and drop counters, each one cycle behind its event
    always_ff @(posedge clk) begin
        if (reset) begin
            runt_r  <= 1'b0;
            ok_r    <= 32'd0;
            err_r   <= 32'd0;
            runts_r <= 32'd0;
        end else begin
            runt_r <= runt_s;
            if (tvalid_r && tlast_r && (tuser_r == 4'd0)) ok_r  <= ok_r + 32'd1;
            if (tvalid_r && tlast_r && (tuser_r != 4'd0)) err_r <= err_r + 32'd1;
            if (runt_r) runts_r <= runts_r + 32'd1;
        end
    end

    assign stat_frames_ok  = ok_r;
    assign stat_frames_err = err_r;
    assign stat_runts      = runts_r;
`else
    logic unused_runt_s;
    assign unused_runt_s = runt_s;
`endif
endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed self-checking bench for mii_rx_framer: each scenario task drives frames and checks beats.
module tb_mii_rx_framer;
    logic clk = 1'b0;
    logic reset;

    mii_rx_framer_if bus();
    mii_rx_framer dut (.clk(clk), .reset(reset), .bus(bus));

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [3:0] u;
        int         c;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] frame_q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int first_nib_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat collector, sampled on the inactive edge
    always @(negedge clk) begin
        if (bus.m_tvalid === 1'b1) beats.push_back('{bus.m_tdata, bus.m_tlast, bus.m_tuser, cyc});
    end

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // len bytes DA..FCS: len-4 pattern bytes then the Ethernet FCS, LSB first
    task automatic build_frame(input int len);
        logic [31:0] crc;
        frame_q.delete();
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < len - 4; i++) begin
            frame_q.push_back(8'((i * 37 + 11) % 256));
            crc = crc_next(crc, frame_q[i]);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) frame_q.push_back(8'(crc >> (8 * i)));
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] nib);
        @(negedge clk);
        bus.mii_rx_dv   = dv;
        bus.mii_rx_er   = er;
        bus.mii_rx_data = nib;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_frame(input int er_nib, input bit extra, input int nbytes);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < nbytes; i++) begin
            drive(1'b1, (er_nib == 2 * i), frame_q[i][3:0]);
            if (i == 0) first_nib_cyc = cyc;
            drive(1'b1, (er_nib == 2 * i + 1), frame_q[i][7:4]);
        end
        if (extra) drive(1'b1, 1'b0, 4'h3);
    endtask

    // Gathers beat statistics against frame_q; a beat is bad on data mismatch or tuser on a non-last beat
    task automatic summarize(output int n, output int bad, output int first_bad, output int nlast,
                             output logic last_l, output logic [3:0] last_u);
        n = beats.size();
        bad = 0;
        first_bad = -1;
        nlast = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= frame_q.size() || beats[i].d !== frame_q[i] || (!beats[i].l && beats[i].u !== 4'd0)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            if (beats[i].l) nlast++;
        end
        last_l = (n > 0) ? beats[n-1].l : 1'b0;
        last_u = (n > 0) ? beats[n-1].u : 4'hF;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata});
        end
        reset = 1'b0;
        idle(4);
        checks++;
        if (beats.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle_beats: got %0d expected 0", beats.size());
        end
    endtask

    // Sends a 64-byte frame (optionally corrupted) and checks beats, tlast, tuser and latency
    task automatic run_64(input string name, input int flip_byte, input int er_nib, input bit extra,
                          input logic [3:0] exp_u, input bit chk_lat);
        int n, bad, fb, nl, lat;
        logic ll;
        logic [3:0] lu;
        beats.delete();
        build_frame(64);
        if (flip_byte >= 0) frame_q[flip_byte] = frame_q[flip_byte] ^ 8'h01;
        send_frame(er_nib, extra, 64);
        idle(12);
        summarize(n, bad, fb, nl, ll, lu);
        checks++;
        if (n !== 60) begin errors++; $display("FAIL %s_count: got %0d expected 60", name, n); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL %s_data: %0d bad beats, first at %0d, expected none", name, bad, fb); end
        checks++;
        if (nl !== 1 || ll !== 1'b1) begin errors++; $display("FAIL %s_tlast: got %0d tlast beats (final=%b) expected 1 on final", name, nl, ll); end
        checks++;
        if (lu !== exp_u) begin errors++; $display("FAIL %s_tuser: got %b expected %b", name, lu, exp_u); end
        if (chk_lat) begin
            // cycles from the edge completing byte 0 to the edge registering its beat
            lat = (n > 0) ? beats[0].c - (first_nib_cyc + 2) : -1;
            checks++;
            if (lat !== 10) begin errors++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end
        end
    endtask

    task automatic test_good();     run_64("good", -1, -1, 1'b0, 4'b0000, 1'b1); endtask
    task automatic test_crc_bad();  run_64("crc_bad", 20, -1, 1'b0, 4'b0001, 1'b0); endtask
    task automatic test_rx_er();    run_64("rx_er", -1, 30, 1'b0, 4'b0010, 1'b0); endtask
    task automatic test_odd();      run_64("odd", -1, -1, 1'b1, 4'b0100, 1'b0); endtask

    task automatic test_min_boundary();
        int n, bad, fb, nl;
        logic ll;
        logic [3:0] lu;
        beats.delete();
        build_frame(5);
        send_frame(-1, 1'b0, 5);
        idle(12);
        summarize(n, bad, fb, nl, ll, lu);
        checks++;
        if (n !== 1 || bad !== 0 || ll !== 1'b1) begin
            errors++;
            $display("FAIL five_byte_beat: got n=%0d bad=%0d last=%b expected n=1 bad=0 last=1", n, bad, ll);
        end
        checks++;
        if (lu !== 4'b1000) begin errors++; $display("FAIL five_byte_tuser: got %b expected 1000", lu); end
    endtask

    task automatic test_runt();
        beats.delete();
        build_frame(8);
        send_frame(-1, 1'b0, 3);
        idle(12);
        checks++;
        if (beats.size() !== 0) begin errors++; $display("FAIL runt_beats: got %0d expected 0", beats.size()); end
        beats.delete();
        build_frame(64);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'h7);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, frame_q[i][3:0]);
            drive(1'b1, 1'b0, frame_q[i][7:4]);
        end
        idle(12);
        checks++;
        if (beats.size() !== 0) begin errors++; $display("FAIL bad_preamble_beats: got %0d expected 0", beats.size()); end
    endtask

    task automatic test_overlong();
        int n, bad, fb, nl;
        logic ll;
        logic [3:0] lu;
        beats.delete();
        build_frame(1600);
        send_frame(-1, 1'b0, 1600);
        idle(12);
        summarize(n, bad, fb, nl, ll, lu);
        checks++;
        if (n !== 1514) begin errors++; $display("FAIL overlong_count: got %0d expected 1514", n); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL overlong_data: %0d bad beats, first at %0d, expected none", bad, fb); end
        checks++;
        if (nl !== 1 || ll !== 1'b1) begin errors++; $display("FAIL overlong_tlast: got %0d tlast beats (final=%b) expected 1 on final", nl, ll); end
        checks++;
        if (lu !== 4'b1000) begin errors++; $display("FAIL overlong_tuser: got %b expected 1000", lu); end
        run_64("after_overlong", -1, -1, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n, bad, fb, nl;
        logic ll;
        logic [3:0] lu;
        beats.delete();
        build_frame(64);
        send_frame(-1, 1'b0, 30);
        @(negedge clk);
        reset = 1'b1;
        bus.mii_rx_dv = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {bus.m_tvalid, bus.m_tlast, bus.m_tuser, bus.m_tdata});
        end
        reset = 1'b0;
        idle(12);
        summarize(n, bad, fb, nl, ll, lu);
        checks++;
        if (n !== 25 || nl !== 0) begin
            errors++;
            $display("FAIL midreset_beats: got n=%0d tlast=%0d expected n=25 tlast=0", n, nl);
        end
        run_64("after_reset", -1, -1, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.mii_rx_dv   = 1'b0;
        bus.mii_rx_er   = 1'b0;
        bus.mii_rx_data = 4'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_good();
        test_crc_bad();
        test_rx_er();
        test_odd();
        test_min_boundary();
        test_runt();
        test_overlong();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
